// File: rtl/alu_arbitro.sv
// Round-robin arbiter and sequencer that shares one external ALU between two requesters.
// Optional per-requester response counters are enabled with `define ALU_ARBITRO_STATS_EN.
module alu_arbitro #(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [ANCHO-1:0] req0_a,
    input  logic [ANCHO-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [ANCHO-1:0] req1_a,
    input  logic [ANCHO-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic [ANCHO-1:0] alu_a,
    output logic [ANCHO-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [ANCHO-1:0] alu_resultado,
    input  logic [3:0]       alu_banderas,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [ANCHO-1:0] rsp_resultado,
    output logic [3:0]       rsp_banderas,
    output logic             rsp_error
`ifdef ALU_ARBITRO_STATS_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_served;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             id_q;
    logic             err_q;
    logic             err_next;
    logic [ANCHO-1:0] a_sel;
    logic [ANCHO-1:0] b_sel;
    logic [3:0]       op_sel;

    // The requester that was not served last wins a tie, so grants alternate.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_served);
        grant1 = req1_valid && (!req0_valid || !last_served);
        accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        a_sel  = req1_ready ? req1_a  : req0_a;
        b_sel  = req1_ready ? req1_b  : req0_b;
        op_sel = req1_ready ? req1_op : req0_op;
        err_next = (op_sel >= 4'd10) ||
                   (((op_sel == 4'd3) || (op_sel == 4'd4)) && (b_sel == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = EXEC;
            EXEC:                   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == IDLE) && grant0;
        req1_ready = (state == IDLE) && grant1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_sel       <= '0;
            err_q         <= 1'b0;
            id_q          <= 1'b0;
            last_served   <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_resultado <= '0;
            rsp_banderas  <= '0;
            rsp_error     <= 1'b0;
        end else begin
            if ((state == IDLE) && accept) begin
                alu_a       <= a_sel;
                alu_b       <= b_sel;
                alu_sel     <= op_sel;
                err_q       <= err_next;
                id_q        <= req1_ready;
                last_served <= req1_ready;
            end
            // Illegal operations report zero result and flags regardless of the ALU.
            if (state == EXEC) begin
                rsp_resultado <= err_q ? '0 : alu_resultado;
                rsp_banderas  <= err_q ? 4'h0 : alu_banderas;
                rsp_error     <= err_q;
                rsp_id        <= id_q;
                rsp_valid     <= 1'b1;
            end
            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARBITRO_STATS_EN
    // Saturating completion counters, bumped on each response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= 8'd0;
            cnt1 <= 8'd0;
        end else if ((state == RESP) && rsp_ready) begin
            if (!rsp_id && (cnt0 != 8'hFF)) cnt0 <= cnt0 + 8'd1;
            if (rsp_id && (cnt1 != 8'hFF))  cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbitro.sv
// Self-checking bench for alu_arbitro: vector table, scoreboard queue and multi-cycle corner cases.
module tb_alu_arbitro;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
    logic [3:0] alu_a, alu_b, alu_sel, alu_resultado, alu_banderas;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_error;
    logic [3:0] rsp_resultado, rsp_banderas;
`ifdef ALU_ARBITRO_STATS_EN
    logic [7:0] cnt0, cnt1;
`endif

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [3:0] res;
        logic       err;
    } vec_t;

    typedef struct {
        logic       id;
        logic [3:0] res;
        logic [3:0] fl;
        logic       err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;
    logic exp_last;

    alu_arbitro #(.ANCHO(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_resultado(alu_resultado), .alu_banderas(alu_banderas),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_resultado(rsp_resultado), .rsp_banderas(rsp_banderas),
        .rsp_error(rsp_error)
`ifdef ALU_ARBITRO_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in combinational ALU; flags are an arbitrary but known mix of its inputs.
    always_comb begin
        case (alu_sel)
            4'd0:    alu_resultado = alu_a + alu_b;
            4'd1:    alu_resultado = alu_a - alu_b;
            4'd2:    alu_resultado = alu_a * alu_b;
            4'd3:    alu_resultado = (alu_b != 4'd0) ? alu_a / alu_b : 4'd0;
            4'd4:    alu_resultado = (alu_b != 4'd0) ? alu_a % alu_b : 4'd0;
            4'd5:    alu_resultado = alu_a & alu_b;
            4'd6:    alu_resultado = alu_a | alu_b;
            4'd7:    alu_resultado = alu_a ^ alu_b;
            4'd8:    alu_resultado = alu_a << alu_b;
            4'd9:    alu_resultado = alu_a >> alu_b;
            default: alu_resultado = 4'hF;
        endcase
        alu_banderas = alu_a ^ alu_b ^ alu_sel;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop and compare on every response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_id",        32'(rsp_id),        32'(e.id));
                checkOutput("rsp_resultado", 32'(rsp_resultado), 32'(e.res));
                checkOutput("rsp_banderas",  32'(rsp_banderas),  32'(e.fl));
                checkOutput("rsp_error",     32'(rsp_error),     32'(e.err));
            end
        end
    end

    task automatic resetDut();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sb.delete();
        exp_last   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic driveReq(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        if (!id) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // One complete operation with rsp_ready held high.
    task automatic applyStimulus(input logic id, input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] op, input logic [3:0] res, input logic err);
        logic [3:0] fl;
        int guard;
        fl = err ? 4'h0 : (a ^ b ^ op);
        @(posedge clk); #1;
        driveReq(id, a, b, op);
        @(negedge clk);
        checkOutput("ready_own",   32'(id ? req1_ready : req0_ready), 32'd1);
        checkOutput("ready_other", 32'(id ? req0_ready : req1_ready), 32'd0);
        sb.push_back('{id, res, fl, err});
        exp_last = id;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        checkOutput("exec_no_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("alu_a",   32'(alu_a),   32'(a));
        checkOutput("alu_b",   32'(alu_b),   32'(b));
        checkOutput("alu_sel", 32'(alu_sel), 32'(op));
        @(negedge clk);
        checkOutput("latency", 32'(rsp_valid), 32'd1);
        guard = 0;
        while (rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rsp_drop", 32'(rsp_valid), 32'd0);
        checkOutput("alu_hold", 32'(alu_a), 32'(a));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int guard;
        logic exp_id;

        vecs[0]  = '{1'b0, 4'd3,  4'd5,  4'd0,  4'd8,  1'b0};
        vecs[1]  = '{1'b1, 4'd9,  4'd3,  4'd1,  4'd6,  1'b0};
        vecs[2]  = '{1'b0, 4'd3,  4'd4,  4'd2,  4'd12, 1'b0};
        vecs[3]  = '{1'b1, 4'd13, 4'd4,  4'd3,  4'd3,  1'b0};
        vecs[4]  = '{1'b0, 4'd13, 4'd4,  4'd4,  4'd1,  1'b0};
        vecs[5]  = '{1'b1, 4'd12, 4'd10, 4'd5,  4'd8,  1'b0};
        vecs[6]  = '{1'b0, 4'd12, 4'd10, 4'd6,  4'd14, 1'b0};
        vecs[7]  = '{1'b1, 4'd12, 4'd10, 4'd7,  4'd6,  1'b0};
        vecs[8]  = '{1'b0, 4'd3,  4'd2,  4'd8,  4'd12, 1'b0};
        vecs[9]  = '{1'b1, 4'd12, 4'd3,  4'd9,  4'd1,  1'b0};
        vecs[10] = '{1'b1, 4'd7,  4'd0,  4'd3,  4'd0,  1'b1};
        vecs[11] = '{1'b0, 4'd7,  4'd0,  4'd4,  4'd0,  1'b1};
        vecs[12] = '{1'b1, 4'd7,  4'd0,  4'd12, 4'd0,  1'b1};
        vecs[13] = '{1'b0, 4'd5,  4'd5,  4'd15, 4'd0,  1'b1};

        req0_a = 4'd0; req0_b = 4'd0; req0_op = 4'd0;
        req1_a = 4'd0; req1_b = 4'd0; req1_op = 4'd0;
        rsp_ready = 1'b1;
        resetDut();

        @(negedge clk);
        checkOutput("rst_req0_ready", 32'(req0_ready),    32'd0);
        checkOutput("rst_req1_ready", 32'(req1_ready),    32'd0);
        checkOutput("rst_rsp_valid",  32'(rsp_valid),     32'd0);
        checkOutput("rst_alu_a",      32'(alu_a),         32'd0);
        checkOutput("rst_alu_b",      32'(alu_b),         32'd0);
        checkOutput("rst_alu_sel",    32'(alu_sel),       32'd0);
        checkOutput("rst_rsp_res",    32'(rsp_resultado), 32'd0);
        checkOutput("rst_rsp_flags",  32'(rsp_banderas),  32'd0);
        checkOutput("rst_rsp_error",  32'(rsp_error),     32'd0);
        checkOutput("rst_rsp_id",     32'(rsp_id),        32'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].err);
        end

        // Contention right after reset: expect grants 0,1,0,1.
        resetDut();
        @(posedge clk); #1;
        driveReq(1'b0, 4'd3, 4'd5, 4'd0);
        driveReq(1'b1, 4'd9, 4'd3, 4'd1);
        for (int g = 0; g < 4; g++) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!(req0_ready || req1_ready) && guard < 10);
            exp_id = ~exp_last;
            checkOutput("grant_seen",   32'(req0_ready | req1_ready), 32'd1);
            checkOutput("grant_order",  32'(req1_ready),              32'(exp_id));
            checkOutput("grant_onehot", 32'(req0_ready & req1_ready), 32'd0);
            if (exp_id) sb.push_back('{1'b1, 4'd6, 4'hB, 1'b0});
            else        sb.push_back('{1'b0, 4'd8, 4'h6, 1'b0});
            exp_last = exp_id;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("contention_drain", 32'(sb.size()), 32'd0);

        // Backpressure: response held for 5 cycles while both requesters wait.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        driveReq(1'b0, 4'd5, 4'd6, 4'd6);
        @(negedge clk);
        checkOutput("bp_accept", 32'(req0_ready), 32'd1);
        sb.push_back('{1'b0, 4'd7, 4'd5, 1'b0});
        exp_last = 1'b0;
        @(posedge clk); #1;
        driveReq(1'b1, 4'd9, 4'd3, 4'd1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid",  32'(rsp_valid),     32'd1);
            checkOutput("bp_res",    32'(rsp_resultado), 32'd7);
            checkOutput("bp_flags",  32'(rsp_banderas),  32'd5);
            checkOutput("bp_id",     32'(rsp_id),        32'd0);
            checkOutput("bp_ready0", 32'(req0_ready),    32'd0);
            checkOutput("bp_ready1", 32'(req1_ready),    32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(rsp_valid),  32'd0);
        checkOutput("bp_next_ready1",   32'(req1_ready), 32'd1);
        checkOutput("bp_next_ready0",   32'(req0_ready), 32'd0);
        sb.push_back('{1'b1, 4'd6, 4'hB, 1'b0});
        exp_last = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("bp_drain", 32'(sb.size()), 32'd0);

        // Reset pulsed while the operation is in EXEC.
        @(posedge clk); #1;
        driveReq(1'b0, 4'd3, 4'd5, 4'd0);
        @(negedge clk);
        checkOutput("mr_accept", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_async_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mr_async_alu_a", 32'(alu_a),     32'd0);
        #1 rst_n = 1'b1;
        sb.delete();
        exp_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("mr_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        driveReq(1'b0, 4'd3, 4'd5, 4'd0);
        driveReq(1'b1, 4'd9, 4'd3, 4'd1);
        @(negedge clk);
        checkOutput("mr_grant0", 32'(req0_ready), 32'd1);
        checkOutput("mr_grant1", 32'(req1_ready), 32'd0);
        sb.push_back('{1'b0, 4'd8, 4'h6, 1'b0});
        exp_last = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mr_drain", 32'(sb.size()), 32'd0);

`ifdef ALU_ARBITRO_STATS_EN
        resetDut();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 4'd1, 4'd1, 4'd0, 4'd2, 1'b0);
        end
        @(negedge clk);
        checkOutput("cnt0_sat", 32'(cnt0), 32'd255);
        checkOutput("cnt1_zero", 32'(cnt1), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbitro.md
Name: alu_arbitro

Overview:
- Sequencer and round-robin arbiter that shares one ALU instance between two requesters.
- Requester-side handshake: valid/ready with operands and opcode. Response-side handshake: valid/ready with result, flags and error.
- Registers the ALU inputs, runs one evaluation cycle, then captures the ALU's result and flags.
- Sits between the instruction-issue logic and the combinational ALU.

Parameters:
- ANCHO, 4, data width in bits of operands and result. The ALU instance is built with most-significant-bit index ANCHO-1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 accepted this cycle
- req0_a  input  ANCHO  requester 0 operand A
- req0_b  input  ANCHO  requester 0 operand B
- req0_op  input  4  requester 0 ALU select code
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- alu_a  output  ANCHO  registered operand A to the ALU
- alu_b  output  ANCHO  registered operand B to the ALU
- alu_sel  output  4  registered select code to the ALU
- alu_resultado  input  ANCHO  ALU result
- alu_banderas  input  4  ALU flags
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer takes the response
- rsp_id  output  1  requester that issued the response
- rsp_resultado  output  ANCHO  captured result
- rsp_banderas  output  4  captured flags
- rsp_error  output  1  illegal operation

Behaviour:
- Single clock domain. rst_n is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - All outputs are 0, including req*_ready, rsp_valid, alu_* and rsp_*.
  - Last-served pointer = 1, so requester 0 wins the first contention.
- Opcodes: 0 suma, 1 resta, 2 multiplicacion, 3 division, 4 modulo, 5 AND, 6 OR, 7 XOR, 8 shift left, 9 shift right.
- Errors:
  - Codes 10-15 are illegal.
  - Codes 3 and 4 with operand B = 0 are illegal.
- Grant (combinational, IDLE only):
  - If only one requester's valid is high, that requester is granted.
  - If both are high, the requester that is not the last-served one is granted.
- req_i_ready = (state == IDLE) AND grant_i. At most one ready is high in any cycle.
- Handshake accepted at edge k (valid and ready both high):
  - alu_a, alu_b and alu_sel load from the granted requester.
  - The error bit is computed and registered.
  - The id is latched and the last-served pointer is updated.
  - State moves to EXEC.
- EXEC (one cycle). At edge k+1:
  - rsp_resultado and rsp_banderas capture alu_resultado and alu_banderas.
  - If the error bit is set, both capture 0 instead.
  - rsp_error is set from the error bit.
  - rsp_valid goes to 1 and state moves to RESP.
- Fixed latency: acceptance edge to rsp_valid high is 2 edges. Error cases use the same latency.
- RESP:
  - rsp_* outputs hold stable while rsp_valid = 1 and rsp_ready = 0.
  - On an edge with rsp_ready = 1, rsp_valid drops to 0 and state returns to IDLE.
  - A new acceptance is possible at the next edge, giving 3-cycle throughput per operation.
- alu_* outputs hold their last value outside EXEC. They never glitch back to 0.
- Requests with valid high while not in IDLE wait. Requesters must hold valid and payload until ready.
- Reset asserted mid-operation:
  - The in-flight operation is dropped with no response.
  - All registers return to their reset values immediately, without waiting for a clock edge.
- No back-to-back starvation: with both requesters continuously valid, grants strictly alternate.

Optional Feature:
- Macro: ALU_ARBITRO_STATS_EN.
- When defined, two extra output ports exist:
  - cnt0  output  8  completed responses for requester 0
  - cnt1  output  8  completed responses for requester 1
- A count increments on each RESP handshake edge for the matching rsp_id.
- Counts saturate at 255. Error responses are counted.
- Both counts reset to 0.
- When undefined, the ports and counters are absent and the behaviour above is unchanged.

Test Plan:
- Reset then a single request: req0 a=3, b=5, op=0 → req0_ready high in the same cycle. rsp_valid high 2 edges after acceptance, with rsp_id=0, rsp_resultado=8, rsp_error=0.
- Contention: both valid continuously with rsp_ready=1 → grant order 0,1,0,1. Req1 a=9, b=3, op=1 → rsp_resultado=6.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → outputs stable and both ready signals low. Releasing rsp_ready → rsp_valid low next edge, then a new acceptance is possible.
- Divide by zero: req1 a=7, b=0, op=3 → rsp_error=1, rsp_resultado=0, rsp_banderas=0, latency 2. Same check with op=12.
- Reset mid-EXEC: rst_n pulsed low after acceptance → rsp_valid stays 0 and state is IDLE. The next grant goes to requester 0 when both are valid.
- STATS build: 300 req0 operations → cnt0=255, cnt1=0.
